// File: rtl/m_axi_wr.sv
// Single-beat AXI4 write master: one command in flight, B result on rsp port.
// Optional B-wait timeout enabled by defining M_AXI_WR_TIMEOUT_EN.
module m_axi_wr #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ID_W-1:0]     cmd_id_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_data_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [1:0]          rsp_resp_o,
    output logic                rsp_id_err_o
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_aw_done;
    logic                r_w_done;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_strb;
    logic [1:0]          r_resp;
    logic                r_id_err;
    logic                w_accept;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_send_done;
    logic                w_timeout;

    assign w_accept    = (r_state == IDLE) && cmd_valid_i;
    assign w_aw_hs     = (r_state == SEND) && !r_aw_done && awready_i;
    assign w_w_hs      = (r_state == SEND) && !r_w_done && wready_i;
    assign w_send_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

`ifdef M_AXI_WR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counter is held at zero through SEND so it starts clean in WAIT_B.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_cnt <= '0;
        end else if (r_state != WAIT_B) begin
            r_cnt <= '0;
        end else if (!bvalid_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT_B) && !bvalid_i &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        cmd_ready_o = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) w_next = SEND;
            end
            SEND: begin
                awvalid_o = !r_aw_done;
                wvalid_o  = !r_w_done;
                if (w_send_done) w_next = WAIT_B;
            end
            WAIT_B: begin
                bready_o = 1'b1;
                if (bvalid_i || w_timeout) w_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            r_resp    <= 2'b00;
            r_id_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id      <= cmd_id_i;
                r_addr    <= cmd_addr_i;
                r_data    <= cmd_data_i;
                r_strb    <= cmd_strb_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (r_state == WAIT_B) begin
                if (bvalid_i) begin
                    r_resp   <= bresp_i;
                    r_id_err <= (bid_i != r_id);
                end else if (w_timeout) begin
                    r_resp   <= 2'b10;
                    r_id_err <= 1'b0;
                end
            end
        end
    end

    assign awid_o       = r_id;
    assign awaddr_o     = r_addr;
    assign wdata_o      = r_data;
    assign wstrb_o      = r_strb;
    assign rsp_resp_o   = r_resp;
    assign rsp_id_err_o = r_id_err;

endmodule

// File: tb/tb_m_axi_wr.sv
// Self-checking bench for m_axi_wr: directed scenarios plus randomized
// transactions checked against a cycle-timeline model of one AXI write.
module tb_m_axi_wr;

    localparam int TMO = 8;

    logic        clk;
    logic        areset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_id_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic [3:0]  cmd_strb_i;
    logic [3:0]  awid_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [3:0]  bid_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_resp_o;
    logic        rsp_id_err_o;

    int n_checks = 0;
    int n_errors = 0;

    m_axi_wr #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i),
        .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i),
        .bvalid_i(bvalid_i), .bready_o(bready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_resp_o(rsp_resp_o), .rsp_id_err_o(rsp_id_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cmd_valid_i = 1'b0;
        cmd_id_i    = '0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cmd_strb_i  = '0;
        awready_i   = 1'b0;
        wready_i    = 1'b0;
        bid_i       = '0;
        bresp_i     = 2'b00;
        bvalid_i    = 1'b0;
        rsp_ready_i = 1'b0;
    endtask

    // Cycle 0 is the accept cycle. The expected timeline is derived from
    // the delays: AW/W handshakes, B handshake, response, next accept.
    task automatic run_txn(
        input string       nm,
        input logic [3:0]  id,
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [3:0]  strb,
        input int          aw_dly,
        input int          w_dly,
        input int          b_start,
        input logic [3:0]  bid,
        input logic [1:0]  bresp,
        input int          rsp_dly,
        input bit          busy_valid
    );
        int taw, tw, tb0, tbh, trh, n_aw, n_w;
        logic [1:0] e_resp;
        logic e_err, e;
        taw    = 1 + aw_dly;
        tw     = 1 + w_dly;
        tb0    = ((taw > tw) ? taw : tw) + 1;
        tbh    = (b_start > tb0) ? b_start : tb0;
        e_resp = bresp;
        e_err  = (bid != id);
`ifdef M_AXI_WR_TIMEOUT_EN
        if (tbh > tb0 + TMO - 1) begin
            tbh    = tb0 + TMO - 1;
            e_resp = 2'b10;
            e_err  = 1'b0;
        end
`endif
        trh  = tbh + 1 + rsp_dly;
        n_aw = 0;
        n_w  = 0;
        for (int t = 0; t <= trh; t++) begin
            cmd_valid_i = (t == 0) ? 1'b1 : busy_valid;
            cmd_id_i    = (t == 0) ? id : 4'($urandom);
            cmd_addr_i  = (t == 0) ? addr : $urandom;
            cmd_data_i  = (t == 0) ? data : $urandom;
            cmd_strb_i  = (t == 0) ? strb : 4'($urandom);
            awready_i   = (t >= taw);
            wready_i    = (t >= tw);
            bvalid_i    = (t >= b_start) && (t <= tbh);
            bid_i       = bid;
            bresp_i     = bresp;
            rsp_ready_i = (t >= trh);
            @(negedge clk);
            e = (t == 0);
            n_checks++;
            if (cmd_ready_o !== e) begin
                n_errors++;
                $display("FAIL %s cmd_ready t=%0d got %b want %b",
                         nm, t, cmd_ready_o, e);
            end
            e = (t >= 1) && (t <= taw);
            n_checks++;
            if (awvalid_o !== e) begin
                n_errors++;
                $display("FAIL %s awvalid t=%0d got %b want %b",
                         nm, t, awvalid_o, e);
            end
            e = (t >= 1) && (t <= tw);
            n_checks++;
            if (wvalid_o !== e) begin
                n_errors++;
                $display("FAIL %s wvalid t=%0d got %b want %b",
                         nm, t, wvalid_o, e);
            end
            if (awvalid_o === 1'b1) begin
                n_checks++;
                if ({awid_o, awaddr_o} !== {id, addr}) begin
                    n_errors++;
                    $display("FAIL %s aw_payload t=%0d got %h/%h want %h/%h",
                             nm, t, awid_o, awaddr_o, id, addr);
                end
            end
            if (wvalid_o === 1'b1) begin
                n_checks++;
                if ({wdata_o, wstrb_o} !== {data, strb}) begin
                    n_errors++;
                    $display("FAIL %s w_payload t=%0d got %h/%b want %h/%b",
                             nm, t, wdata_o, wstrb_o, data, strb);
                end
            end
            e = (t >= tb0) && (t <= tbh);
            n_checks++;
            if (bready_o !== e) begin
                n_errors++;
                $display("FAIL %s bready t=%0d got %b want %b",
                         nm, t, bready_o, e);
            end
            e = (t > tbh);
            n_checks++;
            if (rsp_valid_o !== e) begin
                n_errors++;
                $display("FAIL %s rsp_valid t=%0d got %b want %b",
                         nm, t, rsp_valid_o, e);
            end
            if (t > tbh) begin
                n_checks++;
                if ({rsp_resp_o, rsp_id_err_o} !== {e_resp, e_err}) begin
                    n_errors++;
                    $display("FAIL %s rsp t=%0d got %b/%b want %b/%b",
                             nm, t, rsp_resp_o, rsp_id_err_o, e_resp, e_err);
                end
            end
            if (awvalid_o === 1'b1 && awready_i) n_aw++;
            if (wvalid_o === 1'b1 && wready_i) n_w++;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        n_checks++;
        if (n_aw != 1 || n_w != 1) begin
            n_errors++;
            $display("FAIL %s hs_count got aw=%0d w=%0d want 1/1",
                     nm, n_aw, n_w);
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s ready_after got %b want 1", nm, cmd_ready_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        areset = 1'b0;
        #3;
        n_checks++;
        if ({cmd_ready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o}
            !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset ctrl got %b%b%b%b%b want 10000",
                     cmd_ready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o);
        end
        n_checks++;
        if ({rsp_resp_o, rsp_id_err_o, awid_o, awaddr_o, wdata_o, wstrb_o}
            !== '0) begin
            n_errors++;
            $display("FAIL reset regs got %b %b %h %h %h %b want zeros",
                     rsp_resp_o, rsp_id_err_o, awid_o, awaddr_o,
                     wdata_o, wstrb_o);
        end
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b1;
    endtask

    task automatic test_basic();
        run_txn("basic", 4'd3, 32'h1, 32'hABCDEFAC, 4'b1010,
                0, 0, 0, 4'd3, 2'b00, 0, 1'b0);
    endtask

    task automatic test_data_before_addr();
        run_txn("w_first", 4'd3, 32'h1, 32'hABCDEFAC, 4'b1010,
                4, 0, 0, 4'd3, 2'b00, 0, 1'b0);
    endtask

    task automatic test_addr_before_data();
        run_txn("aw_first", 4'd3, 32'h1, 32'hEFDBCA54, 4'b1010,
                0, 3, 0, 4'd3, 2'b00, 0, 1'b0);
    endtask

    task automatic test_rsp_backpressure();
        run_txn("rsp_bp", 4'd6, 32'h40, 32'h12345678, 4'b1111,
                0, 0, 0, 4'd6, 2'b10, 5, 1'b1);
        run_txn("rsp_bp_next", 4'd7, 32'h44, 32'h9ABCDEF0, 4'b0011,
                0, 0, 0, 4'd7, 2'b00, 0, 1'b0);
    endtask

    task automatic test_id_mismatch();
        run_txn("id_err", 4'd5, 32'h8, 32'h0BADF00D, 4'b1111,
                0, 0, 0, 4'd2, 2'b00, 0, 1'b0);
    endtask

    task automatic test_b_early();
        run_txn("b_early", 4'd1, 32'h10, 32'h55AA55AA, 4'b0101,
                2, 1, 1, 4'd1, 2'b11, 1, 1'b0);
        run_txn("b_late", 4'd9, 32'h14, 32'h11112222, 4'b1000,
                0, 0, 2 + TMO - 1, 4'd9, 2'b01, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cmd_valid_i = 1'b1;
        cmd_id_i    = 4'hC;
        cmd_addr_i  = 32'hCAFE0000;
        cmd_data_i  = 32'hDEADBEEF;
        cmd_strb_i  = 4'hF;
        @(posedge clk);
        #1;
        idle_inputs();
        n_checks++;
        if ({awvalid_o, wvalid_o} !== 2'b11) begin
            n_errors++;
            $display("FAIL rst_mid send got %b%b want 11", awvalid_o, wvalid_o);
        end
        #2;
        areset = 1'b0;
        #1;
        n_checks++;
        if ({awvalid_o, wvalid_o, cmd_ready_o} !== 3'b001) begin
            n_errors++;
            $display("FAIL rst_mid drop got %b%b%b want 001",
                     awvalid_o, wvalid_o, cmd_ready_o);
        end
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready_o, awvalid_o, bready_o, rsp_valid_o} !== 4'b1000) begin
            n_errors++;
            $display("FAIL rst_mid idle got %b%b%b%b want 1000",
                     cmd_ready_o, awvalid_o, bready_o, rsp_valid_o);
        end
        @(posedge clk);
        #1;
        run_txn("after_rst", 4'd2, 32'h20, 32'h76543210, 4'b1100,
                1, 0, 0, 4'd2, 2'b00, 0, 1'b0);
    endtask

    task automatic test_timeout();
`ifdef M_AXI_WR_TIMEOUT_EN
        run_txn("timeout", 4'd4, 32'h30, 32'hFEEDFACE, 4'b1111,
                0, 0, 1000, 4'd4, 2'b00, 1, 1'b0);
`else
        run_txn("long_wait", 4'd4, 32'h30, 32'hFEEDFACE, 4'b1111,
                0, 0, 20, 4'd4, 2'b00, 1, 1'b0);
`endif
    endtask

    task automatic test_random();
        logic [3:0] id, bid;
        for (int i = 0; i < 40; i++) begin
            id  = 4'($urandom);
            bid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : id;
            run_txn("random", id, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 10), bid, 2'($urandom),
                    $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_data_before_addr();
        test_addr_before_data();
        test_rsp_backpressure();
        test_id_mismatch();
        test_b_early();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
